fsm_ctx_scheduler: RTL and testbench

- Time-shares one "101" Moore sequence-detector datapath (states A/B/C/D, output high in D) across NUM_CH independent serial bit streams.
- Keeps one 2-bit state context per channel.
- A round-robin arbiter picks one requesting channel per cycle, steps that channel's context with the offered bit, and writes the context back.
- Reports the channel's new Moore output one cycle later.
- Sits between per-channel serial front-ends and the match-event collector.

---
 rtl/fsm_ctx_pkg.sv | 25 ++
 rtl/fsm_ctx_scheduler_if.sv | 29 ++
 rtl/fsm_ctx_scheduler_rr_arbiter.sv | 54 +++++
 rtl/fsm_ctx_scheduler.sv | 86 ++++++++
 tb/tb_fsm_ctx_scheduler.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/fsm_ctx_pkg.sv
// Shared types and next-state/output functions for the "101" Moore detector.
// The same functions are used by the standalone detector and by the
// context-switched scheduler, so both step the machine identically.
package fsm_ctx_pkg;

  typedef enum logic [1:0] {ST_A = 2'd0, ST_B = 2'd1, ST_C = 2'd2, ST_D = 2'd3} state_t;

  // Next state for one input bit. The default arm treats any unexpected
  // value as A, so a corrupted context recovers on its next step.
  function automatic state_t fsm_next(input state_t s, input logic b);
    case (s)
      ST_A:    return b ? ST_B : ST_A;
      ST_B:    return b ? ST_B : ST_C;
      ST_C:    return b ? ST_D : ST_A;
      ST_D:    return b ? ST_B : ST_C;
      default: return b ? ST_B : ST_A;
    endcase
  endfunction

  // Moore output: high only in D.
  function automatic logic fsm_out(input state_t s);
    return (s == ST_D);
  endfunction

endpackage

// File: rtl/fsm_ctx_scheduler_if.sv
// Request/grant/result bundle between the per-channel serial front-ends
// (master) and the context scheduler (slave).
//   req, bit_in, clr : per-channel request, offered bit, context clear
//   gnt              : one-hot grant, combinational
//   res_valid/ch/match : registered result, one per grant
interface fsm_ctx_scheduler_if #(
  parameter int NUM_CH = 4
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] bit_in;
  logic [NUM_CH-1:0] clr;
  logic [NUM_CH-1:0] gnt;
  logic              res_valid;
  logic [CH_W-1:0]   res_ch;
  logic              res_match;

  modport master (
    output req, bit_in, clr,
    input  gnt, res_valid, res_ch, res_match
  );

  modport slave (
    input  req, bit_in, clr,
    output gnt, res_valid, res_ch, res_match
  );

endinterface

// File: rtl/fsm_ctx_scheduler_rr_arbiter.sv
// Round-robin arbiter over N eligible requesters.
//   clk, areset  : clock, async active-high reset (rr_ptr -> 0, gnt forced 0)
//   elig         : per-requester eligibility
//   grant_accept : lets rr_ptr advance past the granted index
//   gnt          : one-hot grant (combinational from elig and rr_ptr)
//   gnt_idx      : binary index of the granted requester
//   gnt_any      : some requester is granted
module rr_arbiter #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         areset,
  input  logic [N-1:0] elig,
  input  logic         grant_accept,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_any
);

  logic [W-1:0] rr_ptr;
  logic [W:0]   sum;
  logic [W-1:0] idx;

  // Scan N positions starting at rr_ptr; the extra bit in sum lets the
  // wrap be a single conditional subtract, valid for non-power-of-2 N.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    sum     = '0;
    idx     = '0;
    if (!areset) begin
      for (int k = 0; k < N; k++) begin
        sum = {1'b0, rr_ptr} + (W+1)'(k);
        if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
        idx = sum[W-1:0];
        if (!gnt_any && elig[idx]) begin
          gnt[idx] = 1'b1;
          gnt_idx  = idx;
          gnt_any  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset)
      rr_ptr <= '0;
    else if (gnt_any && grant_accept)
      rr_ptr <= (gnt_idx == W'(N-1)) ? '0 : gnt_idx + 1'b1;
  end

endmodule

// File: rtl/fsm_ctx_scheduler.sv
// Time-shares one "101" Moore detector across NUM_CH serial streams.
// One 2-bit context per channel; the round-robin winner's context is stepped
// with its offered bit and written back, and the new Moore output is
// reported one cycle later.
//   clk, areset : clock, async active-high reset
//   bus (slave) : req/bit_in/clr in, gnt out (comb), res_valid/res_ch/res_match out (reg)
module fsm_ctx_scheduler
  import fsm_ctx_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic clk,
  input  logic areset,
  fsm_ctx_scheduler_if.slave bus
);

  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] gnt;
  logic [CH_W-1:0]   gnt_idx;
  logic              gnt_any;
  state_t            ctx [NUM_CH];
  state_t            sel_cur;
  state_t            sel_next;
  logic              sel_bit;

  // A clear on a channel masks its request so the bit is not consumed
  // while the context is being forced to A.
  assign elig = bus.req & ~bus.clr;

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk          (clk),
    .areset       (areset),
    .elig         (elig),
    .grant_accept (1'b1),
    .gnt          (gnt),
    .gnt_idx      (gnt_idx),
    .gnt_any      (gnt_any)
  );

  assign bus.gnt = gnt;

  // One-hot mux of the granted channel's context and bit into the shared
  // datapath; avoids indexing ctx with a binary value that could exceed
  // NUM_CH-1 for non-power-of-2 sizes.
  always_comb begin
    sel_cur = ST_A;
    sel_bit = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) begin
        sel_cur = ctx[i];
        sel_bit = bus.bit_in[i];
      end
    end
    sel_next = fsm_next(sel_cur, sel_bit);
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_CH; i++) ctx[i] <= ST_A;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.clr[i])
          ctx[i] <= ST_A;
        else if (gnt[i])
          ctx[i] <= sel_next;
      end
    end
  end

  // Result register: res_ch/res_match hold when nothing is granted.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      bus.res_valid <= 1'b0;
      bus.res_ch    <= '0;
      bus.res_match <= 1'b0;
    end else if (gnt_any) begin
      bus.res_valid <= 1'b1;
      bus.res_ch    <= gnt_idx;
      bus.res_match <= fsm_out(sel_next);
    end else begin
      bus.res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fsm_ctx_scheduler.sv
module tb_fsm_ctx_scheduler;

  logic clk;
  logic areset;
  int   checks;
  int   errors;

  fsm_ctx_scheduler_if #(.NUM_CH(4)) if4 ();
  fsm_ctx_scheduler_if #(.NUM_CH(3)) if3 ();

  fsm_ctx_scheduler #(.NUM_CH(4)) u4 (.clk(clk), .areset(areset), .bus(if4));
  fsm_ctx_scheduler #(.NUM_CH(3)) u3 (.clk(clk), .areset(areset), .bus(if3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle_inputs();
    if4.req = '0; if4.bit_in = '0; if4.clr = '0;
    if3.req = '0; if3.bit_in = '0; if3.clr = '0;
  endtask

  // Leaves the bench just after a rising edge with reset released.
  task automatic apply_reset();
    idle_inputs();
    areset = 1'b1;
    @(posedge clk); #1;
    areset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic b2 [3] = '{1'b1, 1'b0, 1'b1};
    logic b2p [2] = '{1'b0, 1'b1};
    // power-up: reset held across an edge, requests pending
    if4.req = 4'b1111;
    @(posedge clk); #2;
    checks++; if (if4.gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt: got %b want 0000", if4.gnt); end
    checks++; if (if4.res_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", if4.res_valid); end
    checks++; if (if4.res_ch !== 2'd0) begin errors++; $display("FAIL rst_ch: got %0d want 0", if4.res_ch); end
    areset = 1'b0;
    // drive ch2 into D
    for (int k = 0; k < 3; k++) begin
      if4.req = 4'b0100; if4.bit_in = {1'b0, b2[k], 2'b00};
      @(posedge clk); #1;
    end
    checks++; if (if4.res_valid !== 1'b1 || if4.res_ch !== 2'd2 || if4.res_match !== 1'b1)
      begin errors++; $display("FAIL pre_rst: got v%b ch%0d m%b want v1 ch2 m1", if4.res_valid, if4.res_ch, if4.res_match); end
    // asynchronous reset mid-cycle
    #2; areset = 1'b1; #1;
    checks++; if (if4.res_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b want 0", if4.res_valid); end
    checks++; if (if4.res_ch !== 2'd0) begin errors++; $display("FAIL async_ch: got %0d want 0", if4.res_ch); end
    checks++; if (if4.res_match !== 1'b0) begin errors++; $display("FAIL async_match: got %b want 0", if4.res_match); end
    checks++; if (if4.gnt !== 4'b0000) begin errors++; $display("FAIL async_gnt: got %b want 0000", if4.gnt); end
    @(posedge clk); #1;
    areset = 1'b0;
    // from A, bits 0,1 give A,B (from D they would give C,D)
    for (int k = 0; k < 2; k++) begin
      if4.req = 4'b0100; if4.bit_in = {1'b0, b2p[k], 2'b00};
      @(posedge clk); #1;
      checks++; if (if4.res_valid !== 1'b1 || if4.res_ch !== 2'd2 || if4.res_match !== 1'b0)
        begin errors++; $display("FAIL post_rst%0d: got v%b ch%0d m%b want v1 ch2 m0", k, if4.res_valid, if4.res_ch, if4.res_match); end
    end
    idle_inputs();
  endtask

  task automatic test_single_stream();
    logic bs [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic em [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      if4.req = 4'b0001; if4.bit_in = {3'b000, bs[k]};
      @(negedge clk);
      checks++; if (if4.gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt%0d: got %b want 0001", k, if4.gnt); end
      @(posedge clk); #1;
      checks++; if (if4.res_valid !== 1'b1 || if4.res_ch !== 2'd0 || if4.res_match !== em[k])
        begin errors++; $display("FAIL single_res%0d: got v%b ch%0d m%b want v1 ch0 m%b", k, if4.res_valid, if4.res_ch, if4.res_match, em[k]); end
    end
    idle_inputs();
    @(posedge clk); #1;
    checks++; if (if4.res_valid !== 1'b0 || if4.res_ch !== 2'd0 || if4.res_match !== 1'b1)
      begin errors++; $display("FAIL idle_hold: got v%b ch%0d m%b want v0 ch0 m1", if4.res_valid, if4.res_ch, if4.res_match); end
  endtask

  task automatic test_fairness();
    logic [3:0] eg;
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      if4.req = 4'b1111; if4.bit_in = 4'b1111;
      eg = 4'b0001 << (k % 4);
      @(negedge clk);
      checks++; if (if4.gnt !== eg) begin errors++; $display("FAIL fair_gnt%0d: got %b want %b", k, if4.gnt, eg); end
      @(posedge clk); #1;
      checks++; if (if4.res_valid !== 1'b1 || if4.res_ch !== 2'(k % 4))
        begin errors++; $display("FAIL fair_res%0d: got v%b ch%0d want v1 ch%0d", k, if4.res_valid, if4.res_ch, k % 4); end
    end
    idle_inputs();
  endtask

  task automatic test_isolation();
    logic c1 [3] = '{1'b1, 1'b0, 1'b1};
    logic e1 [3] = '{1'b0, 1'b0, 1'b1};
    int idx;
    int g;
    logic em;
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      idx = (k + 1) / 2;
      if (idx > 2) idx = 2;
      g = (k % 2 == 0) ? 1 : 2;
      em = (g == 1) ? e1[k/2] : 1'b0;
      if4.req = 4'b0110; if4.bit_in = {2'b00, c1[idx], 1'b0};
      @(negedge clk);
      checks++; if (if4.gnt !== (4'b0001 << g)) begin errors++; $display("FAIL iso_gnt%0d: got %b want ch%0d", k, if4.gnt, g); end
      @(posedge clk); #1;
      checks++; if (if4.res_ch !== 2'(g) || if4.res_match !== em)
        begin errors++; $display("FAIL iso_res%0d: got ch%0d m%b want ch%0d m%b", k, if4.res_ch, if4.res_match, g, em); end
    end
    idle_inputs();
  endtask

  task automatic test_clear();
    apply_reset();
    // ch3 to C
    if4.req = 4'b1000; if4.bit_in = 4'b1000;
    @(posedge clk); #1;
    if4.bit_in = 4'b0000;
    @(posedge clk); #1;
    // clear collides with a pending bit 1
    if4.req = 4'b1000; if4.clr = 4'b1000; if4.bit_in = 4'b1000;
    @(negedge clk);
    checks++; if (if4.gnt !== 4'b0000) begin errors++; $display("FAIL clr_gnt: got %b want 0000", if4.gnt); end
    @(posedge clk); #1;
    checks++; if (if4.res_valid !== 1'b0) begin errors++; $display("FAIL clr_valid: got %b want 0", if4.res_valid); end
    // clear on ch3 must not block ch0
    if4.req = 4'b1001; if4.clr = 4'b1000; if4.bit_in = 4'b1000;
    @(negedge clk);
    checks++; if (if4.gnt !== 4'b0001) begin errors++; $display("FAIL clr_other_gnt: got %b want 0001", if4.gnt); end
    @(posedge clk); #1;
    checks++; if (if4.res_valid !== 1'b1 || if4.res_ch !== 2'd0 || if4.res_match !== 1'b0)
      begin errors++; $display("FAIL clr_other_res: got v%b ch%0d m%b want v1 ch0 m0", if4.res_valid, if4.res_ch, if4.res_match); end
    // bit 1 now steps A->B, not C->D
    if4.req = 4'b1000; if4.clr = 4'b0000; if4.bit_in = 4'b1000;
    @(negedge clk);
    checks++; if (if4.gnt !== 4'b1000) begin errors++; $display("FAIL clr_after_gnt: got %b want 1000", if4.gnt); end
    @(posedge clk); #1;
    checks++; if (if4.res_valid !== 1'b1 || if4.res_ch !== 2'd3 || if4.res_match !== 1'b0)
      begin errors++; $display("FAIL clr_after_res: got v%b ch%0d m%b want v1 ch3 m0", if4.res_valid, if4.res_ch, if4.res_match); end
    idle_inputs();
  endtask

  task automatic test_wrap3();
    int order [4] = '{2, 0, 2, 0};
    apply_reset();
    // grant ch1 once so rr_ptr becomes 2
    if3.req = 3'b010;
    @(negedge clk);
    checks++; if (if3.gnt !== 3'b010) begin errors++; $display("FAIL wrap_pre_gnt: got %b want 010", if3.gnt); end
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      if3.req = 3'b101; if3.bit_in = 3'b000;
      @(negedge clk);
      checks++; if (if3.gnt !== (3'b001 << order[k])) begin errors++; $display("FAIL wrap_gnt%0d: got %b want ch%0d", k, if3.gnt, order[k]); end
      @(posedge clk); #1;
      checks++; if (if3.res_valid !== 1'b1 || if3.res_ch !== 2'(order[k]))
        begin errors++; $display("FAIL wrap_res%0d: got v%b ch%0d want v1 ch%0d", k, if3.res_valid, if3.res_ch, order[k]); end
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    areset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_stream();
    test_fairness();
    test_isolation();
    test_clear();
    test_wrap3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
